// File: rtl/cpu_pkg.sv
// Shared core constants: PC register index, PC read offset and the
// address-width helper used to size register-file ports.
package cpu_pkg;

    localparam int REG_PC    = 15;
    localparam int PC_OFFSET = 8;

    function automatic int addr_width(input int num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits for decode hazard detection: an issue marks the
// destination pending, a writeback to it clears the mark.
module rf_scoreboard
    import cpu_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int AW       = 4,
    parameter int PC_IDX   = REG_PC
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                iss_en_i,
    input  logic [AW-1:0]       iss_addr_i,
    input  logic                wr0_en_i,
    input  logic [AW-1:0]       wr0_addr_i,
    input  logic                wr1_en_i,
    input  logic [AW-1:0]       wr1_addr_i,
    output logic [NUM_REGS-1:0] busy_o
);

    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] busy_q;

    // A new issue beats a same-edge writeback: the writeback belongs to the older producer.
    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (iss_en_i && (iss_addr_i == AW'(r)) && (r != PC_IDX)) begin
                busy_d[r] = 1'b1;
            end else if ((wr0_en_i && (wr0_addr_i == AW'(r))) ||
                         (wr1_en_i && (wr1_addr_i == AW'(r)))) begin
                busy_d[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with two writeback ports, same-edge write->read
// bypass, PC substitution on the PC index and a scoreboard for hazard stalls.
module reg_file_mp
    import cpu_pkg::*;
#(
    parameter int  DATA_W   = 32,
    parameter int  NUM_REGS = 16,
    parameter int  NUM_RD   = 3,
    parameter int  PC_IDX   = REG_PC,
    parameter int  PC_OFS   = PC_OFFSET,
    localparam int AW       = addr_width(NUM_REGS)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NUM_RD*AW-1:0]     rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    input  logic [DATA_W-1:0]        pc_i,
    input  logic                     wr0_en_i,
    input  logic [AW-1:0]            wr0_addr_i,
    input  logic [DATA_W-1:0]        wr0_data_i,
    input  logic                     wr1_en_i,
    input  logic [AW-1:0]            wr1_addr_i,
    input  logic [DATA_W-1:0]        wr1_data_i,
    input  logic                     iss_en_i,
    input  logic [AW-1:0]            iss_addr_i,
    output logic [NUM_REGS-1:0]      busy_o
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [DATA_W-1:0] pc_read;
    logic              wr0_ok;
    logic              wr1_ok;

    function automatic logic addr_in_range(input logic [AW-1:0] a);
        return ({1'b0, a} < (AW+1)'(NUM_REGS));
    endfunction

    assign wr0_ok  = wr0_en_i && (wr0_addr_i != AW'(PC_IDX)) && addr_in_range(wr0_addr_i);
    assign wr1_ok  = wr1_en_i && (wr1_addr_i != AW'(PC_IDX)) && addr_in_range(wr1_addr_i);
    assign pc_read = pc_i + DATA_W'(PC_OFS);

    // wr0 is applied last so it wins a same-address collision; regs_d doubles as the bypass source.
    always_comb begin
        regs_d = regs_q;
        if (wr1_ok) begin
            regs_d[wr1_addr_i] = wr1_data_i;
        end
        if (wr0_ok) begin
            regs_d[wr0_addr_i] = wr0_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0]     addr;
        logic [DATA_W-1:0] rd_d;
        logic [DATA_W-1:0] rd_q;

        assign addr = rd_addr_i[k*AW +: AW];

        always_comb begin
            if (addr == AW'(PC_IDX)) begin
                rd_d = pc_read;
            end else if (!addr_in_range(addr)) begin
                rd_d = '0;
            end else begin
                rd_d = regs_d[addr];
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rd_q <= '0;
            end else begin
                rd_q <= rd_d;
            end
        end

        assign rd_data_o[k*DATA_W +: DATA_W] = rd_q;
    end

    rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .AW       (AW),
        .PC_IDX   (PC_IDX)
    ) u_scoreboard (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .iss_en_i   (iss_en_i),
        .iss_addr_i (iss_addr_i),
        .wr0_en_i   (wr0_en_i),
        .wr0_addr_i (wr0_addr_i),
        .wr1_en_i   (wr1_en_i),
        .wr1_addr_i (wr1_addr_i),
        .busy_o     (busy_o)
    );

endmodule
